// File: rtl/reg_byte_assembler.sv
// Assembles byte-wide bus writes into 16-bit register writes and serves byte
// reads from a one-word read buffer, fetching on a miss with a bounded wait.
module reg_byte_assembler #(
  parameter int RD_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        write_strobe_i,
  input  logic        read_strobe_i,
  input  logic [3:0]  reg_num_i,
  input  logic        bytesel_i,
  input  logic [7:0]  bytedata_i,
  output logic        reg_wr_o,
  output logic [3:0]  reg_wr_num_o,
  output logic [15:0] reg_wr_data_o,
  output logic        reg_rd_req_o,
  output logic [3:0]  reg_rd_num_o,
  input  logic        reg_rd_ack_i,
  input  logic [15:0] reg_rd_data_i,
  output logic [7:0]  bus_data_o,
  output logic        dtack_o,
  output logic        debug_state
);

  localparam logic DTACK_ACK = 1'b1;
  localparam logic DTACK_NAK = 1'b0;
  localparam logic [7:0] TMO = 8'(RD_TIMEOUT);

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  // Handshake: write/read strobes are one-cycle qualifiers honoured only in
  // IDLE (write wins if both). dtack_o is a level: NAK from the cycle after an
  // accepted strobe until completion, then ACK held until the next strobe.
  // reg_rd_req_o is a level held until reg_rd_ack_i is sampled or timeout.
  state_t      state, state_next;
  logic [7:0]  hi_byte, hi_byte_d;
  logic [15:0] rd_buf, rd_buf_d;
  logic [3:0]  rd_buf_num, rd_buf_num_d;
  logic        rd_buf_valid, rd_buf_valid_d;
  logic        rd_sel, rd_sel_d;
  logic [7:0]  cnt, cnt_d;
  logic        wr_d, rd_req_d, dtack_d;
  logic [3:0]  wr_num_d, rd_num_d;
  logic [15:0] wr_data_d;
  logic [7:0]  bus_data_d;
  logic        wr_go, rd_go, rd_hit, rd_miss, ack_go, tmo_go;

  assign wr_go   = (state == IDLE) && write_strobe_i;
  assign rd_go   = (state == IDLE) && read_strobe_i && !write_strobe_i;
  assign rd_hit  = rd_go && bytesel_i && rd_buf_valid && (rd_buf_num == reg_num_i);
  assign rd_miss = rd_go && !rd_hit;
  assign ack_go  = (state == RD_WAIT) && reg_rd_ack_i;
  assign tmo_go  = (state == RD_WAIT) && !reg_rd_ack_i && (cnt == TMO);

  assign debug_state = (state == RD_WAIT);

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= IDLE;
      hi_byte       <= 8'h00;
      rd_buf        <= 16'h0000;
      rd_buf_num    <= 4'h0;
      rd_buf_valid  <= 1'b0;
      rd_sel        <= 1'b0;
      cnt           <= 8'h00;
      reg_wr_o      <= 1'b0;
      reg_wr_num_o  <= 4'h0;
      reg_wr_data_o <= 16'h0000;
      reg_rd_req_o  <= 1'b0;
      reg_rd_num_o  <= 4'h0;
      bus_data_o    <= 8'h00;
      dtack_o       <= DTACK_NAK;
    end else begin
      state         <= state_next;
      hi_byte       <= hi_byte_d;
      rd_buf        <= rd_buf_d;
      rd_buf_num    <= rd_buf_num_d;
      rd_buf_valid  <= rd_buf_valid_d;
      rd_sel        <= rd_sel_d;
      cnt           <= cnt_d;
      reg_wr_o      <= wr_d;
      reg_wr_num_o  <= wr_num_d;
      reg_wr_data_o <= wr_data_d;
      reg_rd_req_o  <= rd_req_d;
      reg_rd_num_o  <= rd_num_d;
      bus_data_o    <= bus_data_d;
      dtack_o       <= dtack_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rd_miss) state_next = RD_WAIT;
      RD_WAIT: if (ack_go || tmo_go) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    hi_byte_d      = hi_byte;
    rd_buf_d       = rd_buf;
    rd_buf_num_d   = rd_buf_num;
    rd_buf_valid_d = rd_buf_valid;
    rd_sel_d       = rd_sel;
    cnt_d          = cnt;
    wr_d           = 1'b0;
    wr_num_d       = reg_wr_num_o;
    wr_data_d      = reg_wr_data_o;
    rd_req_d       = reg_rd_req_o;
    rd_num_d       = reg_rd_num_o;
    bus_data_d     = bus_data_o;
    dtack_d        = dtack_o;

    if (wr_go) begin
      dtack_d = DTACK_ACK;
      if (bytesel_i) begin
        wr_d      = 1'b1;
        wr_num_d  = reg_num_i;
        wr_data_d = {hi_byte, bytedata_i};
      end else begin
        hi_byte_d = bytedata_i;
      end
      // Any write to the buffered register makes the buffered copy stale.
      if (reg_num_i == rd_buf_num) rd_buf_valid_d = 1'b0;
    end else if (rd_hit) begin
      bus_data_d = rd_buf[7:0];
      dtack_d    = DTACK_ACK;
    end else if (rd_miss) begin
      dtack_d  = DTACK_NAK;
      rd_req_d = 1'b1;
      rd_num_d = reg_num_i;
      rd_sel_d = bytesel_i;
      cnt_d    = 8'h00;
    end else if (ack_go) begin
      rd_buf_d       = reg_rd_data_i;
      rd_buf_num_d   = reg_rd_num_o;
      rd_buf_valid_d = 1'b1;
      rd_req_d       = 1'b0;
      bus_data_d     = rd_sel ? reg_rd_data_i[7:0] : reg_rd_data_i[15:8];
      dtack_d        = DTACK_ACK;
    end else if (tmo_go) begin
      rd_buf_valid_d = 1'b0;
      rd_req_d       = 1'b0;
      bus_data_d     = 8'hFF;
      dtack_d        = DTACK_ACK;
    end else if (state == RD_WAIT) begin
      cnt_d = cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_reg_byte_assembler.sv
// Directed bench for reg_byte_assembler: write assembly, buffered reads,
// timeout, invalidation, dropped strobes and asynchronous reset abort.
module tb_reg_byte_assembler;

  localparam int RD_TIMEOUT = 15;
  localparam logic ACK = 1'b1;
  localparam logic NAK = 1'b0;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        write_strobe_i = 1'b0;
  logic        read_strobe_i = 1'b0;
  logic [3:0]  reg_num_i = 4'h0;
  logic        bytesel_i = 1'b0;
  logic [7:0]  bytedata_i = 8'h00;
  logic        reg_wr_o;
  logic [3:0]  reg_wr_num_o;
  logic [15:0] reg_wr_data_o;
  logic        reg_rd_req_o;
  logic [3:0]  reg_rd_num_o;
  logic        reg_rd_ack_i = 1'b0;
  logic [15:0] reg_rd_data_i = 16'h0000;
  logic [7:0]  bus_data_o;
  logic        dtack_o;
  logic        debug_state;

  int checks = 0;
  int errors = 0;
  logic [19:0] wr_exp_q[$];
  logic [7:0]  rd_exp_q[$];
  logic [7:0]  hi_model = 8'h00;

  reg_byte_assembler #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .reset_n_i(reset_n_i),
    .write_strobe_i(write_strobe_i), .read_strobe_i(read_strobe_i),
    .reg_num_i(reg_num_i), .bytesel_i(bytesel_i), .bytedata_i(bytedata_i),
    .reg_wr_o(reg_wr_o), .reg_wr_num_o(reg_wr_num_o), .reg_wr_data_o(reg_wr_data_o),
    .reg_rd_req_o(reg_rd_req_o), .reg_rd_num_o(reg_rd_num_o),
    .reg_rd_ack_i(reg_rd_ack_i), .reg_rd_data_i(reg_rd_data_i),
    .bus_data_o(bus_data_o), .dtack_o(dtack_o), .debug_state(debug_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // scoreboard for 16-bit register writes
  always @(negedge clk) begin
    if (reset_n_i && reg_wr_o === 1'b1) begin
      if (wr_exp_q.size() == 0) check("wr_unexpected", {12'h0, reg_wr_num_o, reg_wr_data_o}, 32'hFFFF_FFFF);
      else check("wr_word", {12'h0, reg_wr_num_o, reg_wr_data_o}, {12'h0, wr_exp_q.pop_front()});
    end
  end

  task automatic do_write(input logic [3:0] num, input logic sel, input logic [7:0] data,
                          input logic also_read);
    if (sel) wr_exp_q.push_back({num, hi_model, data});
    else hi_model = data;
    write_strobe_i = 1'b1; read_strobe_i = also_read;
    reg_num_i = num; bytesel_i = sel; bytedata_i = data;
    cyc();
    write_strobe_i = 1'b0; read_strobe_i = 1'b0;
    check("wr_dtack", dtack_o, ACK);
    check("wr_pulse", reg_wr_o, sel);
    check("wr_no_req", reg_rd_req_o, 1'b0);
  endtask

  // ack_delay < 0 means never acknowledge (expect timeout)
  task automatic do_read(input logic [3:0] num, input logic sel, input logic miss,
                         input int ack_delay, input logic [15:0] ack_data,
                         input logic [7:0] exp_byte, input logic inject);
    int n;
    rd_exp_q.push_back(exp_byte);
    read_strobe_i = 1'b1; reg_num_i = num; bytesel_i = sel;
    cyc();
    read_strobe_i = 1'b0;
    check("rd_req", reg_rd_req_o, miss);
    if (miss) begin
      check("rd_nak", dtack_o, NAK);
      check("rd_num", reg_rd_num_o, num);
      if (ack_delay >= 0) begin
        for (int i = 0; i < ack_delay; i++) begin
          if (inject && i < 2) begin
            write_strobe_i = 1'b1; bytesel_i = i[0]; bytedata_i = 8'h99; reg_num_i = num;
          end
          cyc();
          write_strobe_i = 1'b0;
        end
        check("rd_wait_state", debug_state, 1'b1);
        check("rd_wait_req", reg_rd_req_o, 1'b1);
        reg_rd_ack_i = 1'b1; reg_rd_data_i = ack_data;
        cyc();
        reg_rd_ack_i = 1'b0;
      end else begin
        n = 0;
        while (dtack_o !== ACK && n < 300) begin
          cyc();
          n++;
        end
        check("rd_tmo_cycles", n, RD_TIMEOUT + 1);
      end
    end
    check("rd_dtack", dtack_o, ACK);
    check("rd_req_done", reg_rd_req_o, 1'b0);
    check("rd_idle", debug_state, 1'b0);
    check("rd_byte", bus_data_o, rd_exp_q.pop_front());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr"}, reg_wr_o, 1'b0);
    check({tag, "_wr_num"}, reg_wr_num_o, 4'h0);
    check({tag, "_wr_data"}, reg_wr_data_o, 16'h0000);
    check({tag, "_req"}, reg_rd_req_o, 1'b0);
    check({tag, "_rd_num"}, reg_rd_num_o, 4'h0);
    check({tag, "_bus"}, bus_data_o, 8'h00);
    check({tag, "_dtack"}, dtack_o, NAK);
    check({tag, "_state"}, debug_state, 1'b0);
  endtask

  initial begin
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1 reset_n_i = 1'b1;
    cyc();
    check_reset_outputs("post_reset");

    // even then odd write to reg 3, four cycles apart
    do_write(4'd3, 1'b0, 8'hAB, 1'b0);
    repeat (3) cyc();
    do_write(4'd3, 1'b1, 8'hCD, 1'b0);
    cyc();
    check("wr_single_pulse", reg_wr_o, 1'b0);
    check("wr_dtack_hold", dtack_o, ACK);

    // fetched read then buffered odd read
    do_read(4'd5, 1'b0, 1'b1, 2, 16'h1234, 8'h12, 1'b0);
    do_read(4'd5, 1'b1, 1'b0, 0, 16'h0000, 8'h34, 1'b0);

    // timeout, then the buffer must not serve reg 2
    do_read(4'd2, 1'b0, 1'b1, -1, 16'h0000, 8'hFF, 1'b0);
    do_read(4'd2, 1'b1, 1'b1, 0, 16'hBEEF, 8'hEF, 1'b0);

    // write to the buffered register invalidates it
    do_read(4'd7, 1'b0, 1'b1, 1, 16'hA5C3, 8'hA5, 1'b0);
    do_read(4'd7, 1'b1, 1'b0, 0, 16'h0000, 8'hC3, 1'b0);
    do_write(4'd7, 1'b1, 8'h11, 1'b0);
    do_read(4'd7, 1'b1, 1'b1, 0, 16'h0F0E, 8'h0E, 1'b0);

    // write to another register leaves the buffer valid
    do_write(4'd6, 1'b0, 8'h3C, 1'b0);
    do_read(4'd7, 1'b1, 1'b0, 0, 16'h0000, 8'h0E, 1'b0);

    // ack on the timeout cycle wins
    do_read(4'd8, 1'b0, 1'b1, RD_TIMEOUT, 16'h9A9B, 8'h9A, 1'b0);

    // write strobes during the wait are dropped
    do_read(4'd10, 1'b0, 1'b1, 3, 16'h2468, 8'h24, 1'b1);

    // ack while idle is ignored
    reg_rd_ack_i = 1'b1; reg_rd_data_i = 16'hDEAD;
    cyc();
    reg_rd_ack_i = 1'b0;
    check("idle_ack_bus", bus_data_o, 8'h24);
    check("idle_ack_state", debug_state, 1'b0);
    check("idle_ack_req", reg_rd_req_o, 1'b0);
    do_read(4'd10, 1'b1, 1'b0, 0, 16'h0000, 8'h68, 1'b0);

    // simultaneous strobes: write only (hi byte still 3C)
    do_write(4'd1, 1'b1, 8'h55, 1'b1);
    cyc();
    check("both_no_wait", debug_state, 1'b0);
    check("both_no_req", reg_rd_req_o, 1'b0);

    // reset in the middle of a read, then a late ack
    read_strobe_i = 1'b1; reg_num_i = 4'd9; bytesel_i = 1'b0;
    cyc();
    read_strobe_i = 1'b0;
    cyc();
    check("pre_reset_wait", debug_state, 1'b1);
    #2 reset_n_i = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    hi_model = 8'h00;
    @(posedge clk); #1 reset_n_i = 1'b1;
    reg_rd_ack_i = 1'b1; reg_rd_data_i = 16'h5A5A;
    cyc();
    reg_rd_ack_i = 1'b0;
    check_reset_outputs("late_ack");
    do_write(4'd2, 1'b1, 8'h44, 1'b0);
    do_read(4'd9, 1'b1, 1'b1, 0, 16'h1111, 8'h11, 1'b0);

    cyc();
    check("wr_q_empty", wr_exp_q.size(), 0);
    check("rd_q_empty", rd_exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
